// File: rtl/ota_dec_pkg.sv
// Shared types and constants for the OTA bitstream decimator.
// Consumed by ota_bit_sync and ota_bitstream_decimator via import ota_dec_pkg::*.
package ota_dec_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACQ  = 1'b1
  } dec_state_e;

  localparam int unsigned OSR_LOG2_DEFAULT = 6;

  // A window of 2^osr_log2 strobes can hold every count from 0 up to 2^osr_log2 inclusive.
  function automatic int unsigned sample_width(input int unsigned osr_log2);
    return osr_log2 + 1;
  endfunction

endpackage

// File: rtl/ota_bit_sync.sv
// Two-flop synchroniser for an OTA loopback bit arriving asynchronously to clk.
// Output lags the input by two clk edges; both stages clear on reset.
module ota_bit_sync
  import ota_dec_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      // NOTE: non-blocking keeps these as two distinct flops; blocking would collapse the chain.
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ota_bitstream_decimator.sv
// Decimates the OTA 1-bit pulse-density stream into multi-bit samples on a valid/ready port.
// Default build is a sinc1 ones-count; define DECIM_SINC2_EN for a second-order CIC.
module ota_bitstream_decimator
  import ota_dec_pkg::*;
#(
  parameter int unsigned OSR_LOG2 = OSR_LOG2_DEFAULT,
  parameter int unsigned SW       = sample_width(OSR_LOG2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bit_in,
  input  logic          bit_stb,
  input  logic          run,
  input  logic          clr_ovr,
  output logic [SW-1:0] sample,
  output logic          sample_valid,
  input  logic          sample_ready,
  output logic          overrun,
  output logic          busy
);

  localparam int unsigned OSR = 1 << OSR_LOG2;

  logic                bit_s;
  dec_state_e          state_q;
  logic [OSR_LOG2-1:0] win_cnt_q;
  logic [SW-1:0]       sample_q;
  logic                valid_q;
  logic                ovr_q;

  logic          take;
  logic          leave;
  logic          win_done;
  logic          xfer;
  logic          res_ok;
  logic [SW-1:0] result;

  ota_bit_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bit_in),
    .q_o   (bit_s)
  );

  // Strobes only count while acquiring and still enabled; run=0 wins over a coincident strobe.
  assign take     = (state_q == ACQ) && run && bit_stb;
  assign leave    = (state_q == ACQ) && !run;
  assign win_done = take && (win_cnt_q == OSR_LOG2'(OSR - 1));
  assign xfer     = valid_q && sample_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q <= '0;
    end else if (leave) begin
      win_cnt_q <= '0;
    end else if (take) begin
      win_cnt_q <= win_cnt_q + 1'b1;
    end
  end

`ifdef DECIM_SINC2_EN
  localparam int unsigned IW = 2 * OSR_LOG2 + 1;

  logic [IW-1:0] int1_q, int2_q, dly1_q, dly2_q;
  logic [IW-1:0] int1_d, int2_d, comb1, comb2;
  logic          warm_q;

  // Integrators wrap freely; the comb differences stay exact because the true result fits IW bits.
  assign int1_d = int1_q + IW'(bit_s);
  assign int2_d = int2_q + int1_d;
  assign comb1  = int2_d - dly1_q;
  assign comb2  = comb1 - dly2_q;
  assign result = SW'(comb2 >> OSR_LOG2);
  assign res_ok = win_done && warm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int1_q <= '0;
      int2_q <= '0;
      dly1_q <= '0;
      dly2_q <= '0;
      warm_q <= 1'b0;
    end else if (leave) begin
      int1_q <= '0;
      int2_q <= '0;
      dly1_q <= '0;
      dly2_q <= '0;
      warm_q <= 1'b0;
    end else if (take) begin
      int1_q <= int1_d;
      int2_q <= int2_d;
      if (win_done) begin
        dly1_q <= int2_d;
        dly2_q <= comb1;
        warm_q <= 1'b1;
      end
    end
  end
`else
  logic [SW-1:0] acc_q;
  logic [SW-1:0] acc_d;

  assign acc_d  = acc_q + SW'(bit_s);
  assign result = acc_d;
  assign res_ok = win_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (leave) begin
      acc_q <= '0;
    end else if (take) begin
      acc_q <= win_done ? '0 : acc_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sample_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      if (clr_ovr) ovr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (run) state_q <= ACQ;
        end
        ACQ: begin
          if (!run) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end else begin
            if (xfer) valid_q <= 1'b0;
            // A stalled consumer keeps its sample; the new one is dropped and flagged.
            if (res_ok) begin
              if (valid_q && !sample_ready) begin
                ovr_q <= 1'b1;
              end else begin
                sample_q <= result;
                valid_q  <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;
  assign busy         = (state_q == ACQ);

endmodule

// File: tb/tb_ota_bitstream_decimator.sv
// Self-checking bench for ota_bitstream_decimator: directed scenarios plus randomized traffic,
// all compared against a window-level reference model (sinc1 count or sinc2 triangular FIR).
module tb_ota_bitstream_decimator;

  localparam int OSR_LOG2 = 6;
  localparam int OSR      = 1 << OSR_LOG2;
  localparam int SW       = OSR_LOG2 + 1;
`ifdef DECIM_SINC2_EN
  localparam int FIRST_LAT = 2 * OSR + 1;
`else
  localparam int FIRST_LAT = OSR + 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bit_in = 1'b0;
  logic          bit_stb = 1'b0;
  logic          run = 1'b0;
  logic          clr_ovr = 1'b0;
  logic          sample_ready = 1'b0;
  logic [SW-1:0] sample;
  logic          sample_valid;
  logic          overrun;
  logic          busy;

  ota_bitstream_decimator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bit_in       (bit_in),
    .bit_stb      (bit_stb),
    .run          (run),
    .clr_ovr      (clr_ovr),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Stimulus knobs
  typedef enum {B_ZERO, B_ONE, B_ALT, B_RAND} bit_mode_e;
  bit_mode_e bit_mode = B_ZERO;
  int        stb_div  = 1;    // 0: random strobes, N: one strobe every N cycles
  int        rdy_pct  = 100;
  int        stb_cnt  = 0;
  logic      alt_v    = 1'b0;

  // Reference model state
  bit d1, d2;
  bit m_acq, m_valid, m_ovr;
  int m_sample;
  bit win[$];
  bit prev[$];

  task automatic model_reset();
    d1 = 0; d2 = 0;
    m_acq = 0; m_valid = 0; m_ovr = 0; m_sample = 0;
    win.delete();
    prev.delete();
  endtask

  // Value of a completed window, or -1 when the window produces no sample.
  function automatic int window_result();
`ifdef DECIM_SINC2_EN
    int acc;
    acc = 0;
    if (prev.size() != OSR) return -1;
    for (int j = 1; j <= OSR; j++)
      acc += (j - 1) * int'(prev[j-1]) + (OSR - j + 1) * int'(win[j-1]);
    return acc / OSR;
`else
    int ones;
    ones = 0;
    foreach (win[i]) ones += int'(win[i]);
    return ones;
`endif
  endfunction

  task automatic model_edge();
    bit b;
    bit v_old;
    int r;
    b = d2; d2 = d1; d1 = bit_in;
    v_old = m_valid;
    if (clr_ovr) m_ovr = 0;
    if (!m_acq) begin
      if (run) m_acq = 1;
    end else if (!run) begin
      m_acq = 0; m_valid = 0;
      win.delete(); prev.delete();
    end else begin
      if (v_old && sample_ready) m_valid = 0;
      if (bit_stb) begin
        win.push_back(b);
        if (win.size() == OSR) begin
          r = window_result();
          prev = win;
          win.delete();
          if (r >= 0) begin
            if (v_old && !sample_ready) m_ovr = 1;
            else begin m_sample = r; m_valid = 1; end
          end
        end
      end
    end
  endtask

  task automatic compare();
    check("valid", sample_valid, m_valid);
    check("busy", busy, m_acq);
    check("overrun", overrun, m_ovr);
    if (m_valid) check("sample", sample, m_sample);
  endtask

  task automatic drive();
    if (stb_div == 0) bit_stb = ($urandom_range(0, 99) < 60);
    else begin
      bit_stb = (stb_cnt == 0);
      stb_cnt = (stb_cnt + 1) % stb_div;
    end
    case (bit_mode)
      B_ZERO: bit_in = 1'b0;
      B_ONE:  bit_in = 1'b1;
      B_ALT:  begin bit_in = alt_v; if (bit_stb) alt_v = ~alt_v; end
      default: bit_in = 1'($urandom_range(0, 1));
    endcase
    sample_ready = ($urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
    drive();
  endtask

  task automatic restart(input bit_mode_e m);
    bit_mode = m;
    run = 1'b0;
    repeat (3) step();
    run = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int exp, input int budget, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!sample_valid && cycles < budget);
    check({tag, "_seen"}, sample_valid, 1);
    if (sample_valid) check(tag, sample, exp);
  endtask

  task automatic async_reset();
    @(posedge clk);
    model_edge();
    #2 rst_n = 1'b0;
    #1;
    check("rst_sample", sample, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    compare();
    drive();
  endtask

  initial begin
    int n;
    model_reset();
    #12;
    check("reset_sample", sample, 0);
    check("reset_valid", sample_valid, 0);
    check("reset_overrun", overrun, 0);
    check("reset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive();

    // All ones, strobe every cycle, consumer always ready
    restart(B_ONE);
    wait_valid("ones", OSR, 300, n);
    check("ones_latency", n, FIRST_LAT);
    wait_valid("ones2", OSR, 100, n);
    check("ones_period", n, OSR);
    check("ones_ovr", overrun, 0);

    // Alternating bits
    restart(B_ALT);
    wait_valid("alt", OSR / 2, 300, n);
    wait_valid("alt2", OSR / 2, 100, n);

    // All zeros, strobe every third cycle
    stb_div = 3; stb_cnt = 0;
    restart(B_ZERO);
    wait_valid("zero", 0, 700, n);
    wait_valid("zero2", 0, 300, n);
    check("zero_period", n, 3 * OSR);

    // Backpressure: consumer stalls across two more windows
    stb_div = 1; rdy_pct = 0;
    restart(B_ONE);
    wait_valid("bp", OSR, 300, n);
    repeat (OSR) step();
    bit_mode = B_ZERO;
    repeat (OSR) step();
    check("bp_ovr", overrun, 1);
    check("bp_hold", sample, OSR);
    check("bp_valid", sample_valid, 1);
    rdy_pct = 100; sample_ready = 1'b1;
    step();
    rdy_pct = 0; sample_ready = 1'b0;
    check("bp_xfer", sample_valid, 0);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    check("bp_clr", overrun, 0);

    // run dropped after 40 strobes discards the partial window
    rdy_pct = 100;
    restart(B_ONE);
    repeat (41) step();
    run = 1'b0;
    repeat (2) step();
    check("int_busy", busy, 0);
    check("int_valid", sample_valid, 0);
    repeat (100) step();
    run = 1'b1;
    wait_valid("int_resume", OSR, 300, n);
    check("int_latency", n, FIRST_LAT);

    // Asynchronous reset in the middle of a window
    restart(B_ONE);
    repeat (30) step();
    async_reset();

    // Randomized traffic with occasional run drops and overrun clears
    bit_mode = B_RAND; stb_div = 0; run = 1'b1;
    for (int phase = 0; phase < 2; phase++) begin
      rdy_pct = (phase == 0) ? 50 : 2;
      for (int c = 0; c < 2000; c++) begin
        step();
        if ($urandom_range(0, 299) == 0) run = ~run;
        clr_ovr = ($urandom_range(0, 59) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
